// File: rtl/wishbone_master_port.sv
// Single-transfer Wishbone initiator for one master slot of the shared bus.
// Turns one valid/ready command into one classic cycle and returns exactly
// one response with status OK / ERR / TIMEOUT / RETRY_FAIL.
module wishbone_master_port #(
    parameter int Dw        = 32,
    parameter int Aw        = 32,
    parameter int SELw      = 4,
    parameter int TAGw      = 3,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_GAP = 2
) (
    input  logic            clk,
    input  logic            reset,
    // command side
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [Aw-1:0]   cmd_adr,
    input  logic [Dw-1:0]   cmd_dat,
    input  logic [SELw-1:0] cmd_sel,
    input  logic [TAGw-1:0] cmd_tag,
    // response side
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [Dw-1:0]   rsp_dat,
    output logic [1:0]      rsp_status,
    // Wishbone master slot
    output logic [Aw-1:0]   m_adr_o,
    output logic [Dw-1:0]   m_dat_o,
    output logic [SELw-1:0] m_sel_o,
    output logic [TAGw-1:0] m_tag_o,
    output logic            m_we_o,
    output logic            m_stb_o,
    output logic            m_cyc_o,
    input  logic [Dw-1:0]   m_dat_i,
    input  logic            m_ack_i,
    input  logic            m_err_i,
    input  logic            m_rty_i
);

    localparam int TMOW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RTYW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GAPW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

    // watchdog fires on the edge where the count would reach TIMEOUT
    localparam logic [TMOW-1:0] TMO_LAST = TMOW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [RTYW-1:0] RTY_MAX  = RTYW'(MAX_RETRY);
    localparam logic [GAPW-1:0] GAP_LAST = GAPW'(RETRY_GAP - 1);

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_ERR   = 2'b01;
    localparam logic [1:0] ST_TMO   = 2'b10;
    localparam logic [1:0] ST_RFAIL = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_GAP, S_RESP} state_t;

    state_t          r_state;
    logic [Aw-1:0]   r_adr;
    logic [Dw-1:0]   r_dat;
    logic [SELw-1:0] r_sel;
    logic [TAGw-1:0] r_tag;
    logic            r_we;
    logic            r_cyc;
    logic            r_stb;
    logic            r_rsp_valid;
    logic [Dw-1:0]   r_rsp_dat;
    logic [1:0]      r_rsp_status;
    logic [TMOW-1:0] r_tmo_cnt;
    logic [RTYW-1:0] r_retry_cnt;
    logic [GAPW-1:0] r_gap_cnt;

    logic            w_tmo_fire;
    logic            w_fin;
    logic            w_retry;
    logic [1:0]      w_fin_st;
    logic [Dw-1:0]   w_fin_dat;

    assign w_tmo_fire = (TIMEOUT != 0) && (r_tmo_cnt == TMO_LAST);

    // Resolve the outcome of a BUS cycle: err > ack > rty > watchdog
    always_comb begin
        w_fin     = 1'b0;
        w_retry   = 1'b0;
        w_fin_st  = ST_OK;
        w_fin_dat = '0;
        if (m_err_i) begin
            w_fin    = 1'b1;
            w_fin_st = ST_ERR;
        end else if (m_ack_i) begin
            w_fin     = 1'b1;
            w_fin_dat = r_we ? '0 : m_dat_i;
        end else if (m_rty_i) begin
            if (r_retry_cnt == RTY_MAX) begin
                w_fin    = 1'b1;
                w_fin_st = ST_RFAIL;
            end else begin
                w_retry = 1'b1;
            end
        end else if (w_tmo_fire) begin
            w_fin    = 1'b1;
            w_fin_st = ST_TMO;
        end
    end

    // Transfer FSM with all bus and response outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_adr        <= '0;
            r_dat        <= '0;
            r_sel        <= '0;
            r_tag        <= '0;
            r_we         <= 1'b0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_dat    <= '0;
            r_rsp_status <= ST_OK;
            r_tmo_cnt    <= '0;
            r_retry_cnt  <= '0;
            r_gap_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_adr       <= cmd_adr;
                        r_dat       <= cmd_dat;
                        r_sel       <= cmd_sel;
                        r_tag       <= cmd_tag;
                        r_we        <= cmd_we;
                        r_retry_cnt <= '0;
                        r_tmo_cnt   <= '0;
                        r_cyc       <= 1'b1;
                        r_stb       <= 1'b1;
                        r_state     <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (w_fin) begin
                        r_cyc        <= 1'b0;
                        r_stb        <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_dat    <= w_fin_dat;
                        r_rsp_status <= w_fin_st;
                        r_state      <= S_RESP;
                    end else if (w_retry) begin
                        // dropping cyc hands the grant back to the arbiter
                        r_retry_cnt <= r_retry_cnt + 1'b1;
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_gap_cnt   <= GAP_LAST;
                        r_state     <= S_GAP;
                    end else if (TIMEOUT != 0) begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_tmo_cnt <= '0;
                        r_cyc     <= 1'b1;
                        r_stb     <= 1'b1;
                        r_state   <= S_BUS;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_dat    = r_rsp_dat;
    assign rsp_status = r_rsp_status;
    assign m_adr_o    = r_adr;
    assign m_dat_o    = r_dat;
    assign m_sel_o    = r_sel;
    assign m_tag_o    = r_tag;
    assign m_we_o     = r_we;
    assign m_stb_o    = r_stb;
    assign m_cyc_o    = r_cyc;

endmodule

// File: tb/tb_wishbone_master_port.sv
// Bench for wishbone_master_port: directed and random transfers against a
// per-attempt slave plan; expected outcome derived from the plan alone.
module tb_wishbone_master_port;

    localparam int TMO = 8;
    localparam int MR  = 3;
    localparam int RG  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_we, cmd_ready;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic [2:0]  cmd_tag;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic [31:0] m_adr_o, m_dat_o, m_dat_i;
    logic [3:0]  m_sel_o;
    logic [2:0]  m_tag_o;
    logic        m_we_o, m_stb_o, m_cyc_o, m_ack_i, m_err_i, m_rty_i;

    // second instance with the watchdog disabled, sharing all inputs
    logic        z_cmd_ready, z_rsp_valid, z_we, z_stb, z_cyc;
    logic [31:0] z_rsp_dat, z_adr, z_dat;
    logic [1:0]  z_rsp_status;
    logic [3:0]  z_sel;
    logic [2:0]  z_tag;

    int checks = 0;
    int failures = 0;

    // slave plan: per attempt, wait cycles before terminating, {err,ack,rty}, read data
    int          p_wait [MR+1];
    logic [2:0]  p_term [MR+1];
    logic [31:0] p_dat  [MR+1];

    always #5 clk = ~clk;

    wishbone_master_port #(.TIMEOUT(TMO), .MAX_RETRY(MR), .RETRY_GAP(RG)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_tag(cmd_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_tag_o(m_tag_o),
        .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o),
        .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i)
    );

    wishbone_master_port #(.TIMEOUT(0), .MAX_RETRY(MR), .RETRY_GAP(RG)) u_nt (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(z_cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_tag(cmd_tag),
        .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(z_rsp_dat), .rsp_status(z_rsp_status),
        .m_adr_o(z_adr), .m_dat_o(z_dat), .m_sel_o(z_sel), .m_tag_o(z_tag),
        .m_we_o(z_we), .m_stb_o(z_stb), .m_cyc_o(z_cyc),
        .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic plan_all(input int w, input logic [2:0] t);
        for (int a = 0; a <= MR; a++) begin
            p_wait[a] = w;
            p_term[a] = t;
            p_dat[a]  = $urandom;
        end
    endtask

    // One complete transfer: handshake, play the slave plan, check, back-pressure, release.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [2:0] tag, input int rdly);
        logic [1:0]  e_st;
        logic [31:0] e_dat;
        int e_bus, e_gap, bus, gapc, gap_run, lat, att, wcnt, budget;
        bit fin, stable_ok, gap_ok, busy_ok, hold_ok;

        // reference outcome from the plan
        e_bus = 0; e_gap = 0; fin = 0; e_st = 2'b00; e_dat = 32'h0;
        for (int a = 0; a <= MR && !fin; a++) begin
            if (p_wait[a] >= TMO) begin
                e_bus += TMO; e_st = 2'b10; fin = 1;
            end else begin
                e_bus += p_wait[a] + 1;
                if (p_term[a][2])      begin e_st = 2'b01; fin = 1; end
                else if (p_term[a][1]) begin e_st = 2'b00; e_dat = we ? 32'h0 : p_dat[a]; fin = 1; end
                else if (a == MR)      begin e_st = 2'b11; fin = 1; end
                else                   e_gap += RG;
            end
        end

        check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_tag = tag;
        step();
        lat = 1; bus = 0; gapc = 0; gap_run = 0; att = 0; wcnt = 0; budget = 0;
        stable_ok = 1; gap_ok = 1; busy_ok = 1;
        while (!rsp_valid && budget < 300) begin
            if (cmd_ready) busy_ok = 0;
            // command and rsp_ready wiggle freely; they are ignored while busy
            cmd_valid = 1'($urandom); cmd_we = 1'($urandom); cmd_adr = $urandom;
            cmd_dat = $urandom; cmd_sel = 4'($urandom); cmd_tag = 3'($urandom);
            rsp_ready = 1'($urandom);
            if (m_cyc_o) begin
                if (gap_run > 0) begin
                    if (gap_run != RG) gap_ok = 0;
                    gap_run = 0; att++; wcnt = 0;
                    if (att > MR) att = MR;
                end
                if (m_adr_o !== adr || m_dat_o !== dat || m_sel_o !== sel ||
                    m_tag_o !== tag || m_we_o !== we || m_stb_o !== 1'b1) stable_ok = 0;
                bus++;
                {m_err_i, m_ack_i, m_rty_i} = (wcnt == p_wait[att]) ? p_term[att] : 3'b000;
                m_dat_i = (wcnt == p_wait[att]) ? p_dat[att] : $urandom;
                wcnt++;
            end else begin
                if (m_stb_o) stable_ok = 0;
                gap_run++; gapc++;
                {m_err_i, m_ack_i, m_rty_i} = 3'($urandom);
                m_dat_i = $urandom;
            end
            step();
            lat++; budget++;
        end
        {m_err_i, m_ack_i, m_rty_i} = 3'b000;
        cmd_valid = 1'b0;

        check("rsp_seen", 64'(rsp_valid), 64'(1));
        check("rsp_status", 64'(rsp_status), 64'(e_st));
        check("rsp_dat", 64'(rsp_dat), 64'(e_dat));
        check("bus_cycles", 64'(bus), 64'(e_bus));
        check("gap_cycles", 64'(gapc), 64'(e_gap));
        check("latency", 64'(lat), 64'(e_bus + e_gap + 1));
        check("fields_stable", 64'(stable_ok), 64'(1));
        check("gap_len", 64'(gap_ok), 64'(1));
        check("cmd_ready_busy", 64'(busy_ok), 64'(1));
        check("cyc_low_resp", 64'(m_cyc_o), 64'(0));

        hold_ok = 1;
        for (int i = 0; i < rdly; i++) begin
            rsp_ready = 1'b0;
            step();
            if (rsp_valid !== 1'b1 || rsp_status !== e_st || rsp_dat !== e_dat ||
                cmd_ready !== 1'b0 || m_cyc_o !== 1'b0) hold_ok = 0;
        end
        check("rsp_hold", 64'(hold_ok), 64'(1));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_release", 64'(rsp_valid), 64'(0));
        check("cmd_ready_after", 64'(cmd_ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; cmd_tag = '0; rsp_ready = 1'b0; m_dat_i = '0;
        m_ack_i = 1'b0; m_err_i = 1'b0; m_rty_i = 1'b0;
        #12;
        check("rst_cyc", 64'(m_cyc_o), 64'(0));
        check("rst_stb", 64'(m_stb_o), 64'(0));
        check("rst_we", 64'(m_we_o), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_adr", 64'(m_adr_o), 64'(0));
        check("rst_dat", 64'(m_dat_o), 64'(0));
        check("rst_sel_tag", 64'({m_sel_o, m_tag_o}), 64'(0));
        check("rst_rsp_fields", 64'({rsp_dat, rsp_status}), 64'(0));
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        step();
        reset = 1'b0;
        step();

        // zero-wait read
        plan_all(0, 3'b010); p_dat[0] = 32'hCAFEBABE;
        xfer(1'b0, 32'h100, 32'h0, 4'hF, 3'd1, 0);
        // write with 3 wait states
        plan_all(3, 3'b010);
        xfer(1'b1, 32'h2000, 32'h12345678, 4'hF, 3'd2, 0);
        // rty twice, then ack
        plan_all(0, 3'b001); p_term[2] = 3'b010; p_dat[2] = 32'h5A5A0001;
        xfer(1'b0, 32'h300, 32'h0, 4'h1, 3'd3, 1);
        // rty forever -> retry fail after MR+1 bus cycles
        plan_all(0, 3'b001);
        xfer(1'b0, 32'h400, 32'h0, 4'h3, 3'd4, 0);
        // err together with ack
        plan_all(0, 3'b110);
        xfer(1'b0, 32'h500, 32'h0, 4'hF, 3'd5, 0);
        // ack together with rty
        plan_all(0, 3'b011); p_dat[0] = 32'h0BADF00D;
        xfer(1'b0, 32'h600, 32'h0, 4'hF, 3'd6, 0);
        // silent slave -> watchdog
        plan_all(99, 3'b010);
        xfer(1'b1, 32'h700, 32'hDEAD0001, 4'hC, 3'd7, 0);
        // ack on the very edge the watchdog would fire
        plan_all(TMO - 1, 3'b010); p_dat[0] = 32'h77770007;
        xfer(1'b0, 32'h800, 32'h0, 4'hF, 3'd0, 0);
        // retry, then silence on the re-issue: watchdog restarts per bus entry
        plan_all(2, 3'b001); p_wait[1] = 99;
        xfer(1'b0, 32'h900, 32'h0, 4'hF, 3'd1, 0);
        // back-pressure
        plan_all(1, 3'b010);
        xfer(1'b0, 32'hA00, 32'h0, 4'hF, 3'd2, 5);

        for (int n = 0; n < 30; n++) begin
            for (int a = 0; a <= MR; a++) begin
                p_wait[a] = $urandom_range(0, 9);
                if (p_wait[a] == 9) p_wait[a] = 20;
                p_term[a] = 3'($urandom_range(1, 7));
                p_dat[a]  = $urandom;
            end
            xfer(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom), $urandom_range(0, 3));
        end

        // watchdog disabled instance holds the bus indefinitely
        reset = 1'b1; step(); reset = 1'b0; step();
        {m_err_i, m_ack_i, m_rty_i} = 3'b000; rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'hB00;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 40; i++) step();
        check("nt_cyc_held", 64'(z_cyc), 64'(1));
        check("nt_no_rsp", 64'(z_rsp_valid), 64'(0));
        check("tmo_status", 64'({rsp_valid, rsp_status}), 64'({1'b1, 2'b10}));

        // asynchronous reset: drops z (in BUS) and dut (in RESP) before any edge
        reset = 1'b1;
        #1;
        check("arst_nt_cyc", 64'({z_cyc, z_stb}), 64'(0));
        check("arst_rsp_valid", 64'(rsp_valid), 64'(0));
        step(); reset = 1'b0; step();

        // reset while the dut itself is in BUS
        cmd_valid = 1'b1; cmd_adr = 32'hC00;
        step();
        cmd_valid = 1'b0;
        step();
        check("bus_before_rst", 64'(m_cyc_o), 64'(1));
        reset = 1'b1;
        #1;
        check("arst_bus", 64'({m_cyc_o, m_stb_o, rsp_valid}), 64'(0));
        step(); reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("post_rst_idle", 64'({cmd_ready, rsp_valid, m_cyc_o}), 64'(3'b100));

        plan_all(0, 3'b010); p_dat[0] = 32'h13579BDF;
        xfer(1'b0, 32'hD00, 32'h0, 4'hF, 3'd3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
